// File: rtl/skinny_sbox_layer_serial_d1.sv
// Nibble-serial masked (2-share) Skinny-64 SubCells layer wrapped around a d1 HPC3 S-box pipeline.
// Optional feature macro: SKINNY_SBOX_SHARE_CLEAR_EN (share clearing on start/FIN, outputs masked to 0 while busy).
module skinny_sbox_layer_serial_d1 #(
   parameter int NIBBLES  = 16,
   parameter int SBOX_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] state_in_s0,
   input  logic [4*NIBBLES-1:0] state_in_s1,
   input  logic [7:0]           Fresh,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] state_out_s0,
   output logic [4*NIBBLES-1:0] state_out_s1
);
   localparam int W  = 4*NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int DW = $clog2(SBOX_LAT + 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_t;

   state_t        state, state_nxt;
   logic          accept;
   logic [CW-1:0] feed_cnt;
   logic [DW-1:0] drain_cnt;
   logic [W-1:0]  sh_s0, sh_s1;
   logic [W-1:0]  res_s0, res_s1;
   logic          vld_p [SBOX_LAT];
   logic [CW-1:0] idx_p [SBOX_LAT];

   logic [3:0]    cin_s0, cin_s1;
   logic [3:0]    x_s0_p1, x_s1_p1;
   logic [2:0]    tb_s0_p1, tb_s1_p1, tc_s0_p1, tc_s1_p1;
   logic          b0_s0, b0_s1, c0_s0, c0_s1;
   logic [1:0]    a21_s0_p2, a21_s1_p2, bc_s0_p2, bc_s1_p2;
   logic [2:0]    td_s0_p2, td_s1_p2, te_s0_p2, te_s1_p2;
   logic [3:0]    sbox_s0, sbox_s1;

   // HPC3 d=1 AND share i: {p_i*q_i, p_i*(q_j^r), ~p_i*r ^ r'}; each term is registered on its own.
   function automatic logic [2:0] hpc3_terms(input logic p_i, input logic q_i, input logic q_j,
                                             input logic r, input logic rp);
      return {p_i & q_i, p_i & (q_j ^ r), (~p_i & r) ^ rp};
   endfunction

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = FEED;
            end
         end
         FEED: begin
            busy = 1'b1;
            if (feed_cnt == CW'(NIBBLES-1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == DW'(SBOX_LAT-1)) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         feed_cnt  <= '0;
         drain_cnt <= '0;
         sh_s0     <= '0;
         sh_s1     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sh_s0     <= state_in_s0;
            sh_s1     <= state_in_s1;
            feed_cnt  <= '0;
            drain_cnt <= '0;
         end else if (state == FEED) begin
            // rotate rather than zero-fill: shifted-out nibbles stay behind as residue
            sh_s0    <= {sh_s0[3:0], sh_s0[W-1:4]};
            sh_s1    <= {sh_s1[3:0], sh_s1[W-1:4]};
            feed_cnt <= feed_cnt + 1'b1;
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
`ifdef SKINNY_SBOX_SHARE_CLEAR_EN
         if (state == FIN) begin
            sh_s0 <= '0;
            sh_s1 <= '0;
         end
`endif
      end
   end

   assign cin_s0 = (state == FEED) ? sh_s0[3:0] : 4'h0;
   assign cin_s1 = (state == FEED) ? sh_s1[3:0] : 4'h0;

   // capture index/valid pipeline, aligned to the S-box latency
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SBOX_LAT; i++) begin
            vld_p[i] <= 1'b0;
            idx_p[i] <= '0;
         end
      end else begin
         vld_p[0] <= (state == FEED);
         idx_p[0] <= feed_cnt;
         for (int i = 1; i < SBOX_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            idx_p[i] <= idx_p[i-1];
         end
      end
   end

   // stage p1: b0 = a0 ^ NOR(a3,a2), c0 = a3 ^ NOR(a2,a1); NOR operands are negated on share 0 only
   always_ff @(posedge clk) begin
      tb_s0_p1 <= hpc3_terms(~cin_s0[3], ~cin_s0[2],  cin_s1[2], Fresh[0], Fresh[1]);
      tb_s1_p1 <= hpc3_terms( cin_s1[3],  cin_s1[2], ~cin_s0[2], Fresh[0], Fresh[1]);
      tc_s0_p1 <= hpc3_terms(~cin_s0[2], ~cin_s0[1],  cin_s1[1], Fresh[2], Fresh[3]);
      tc_s1_p1 <= hpc3_terms( cin_s1[2],  cin_s1[1], ~cin_s0[1], Fresh[2], Fresh[3]);
      x_s0_p1  <= cin_s0;
      x_s1_p1  <= cin_s1;
   end

   assign b0_s0 = x_s0_p1[0] ^ (^tb_s0_p1);
   assign b0_s1 = x_s1_p1[0] ^ (^tb_s1_p1);
   assign c0_s0 = x_s0_p1[3] ^ (^tc_s0_p1);
   assign c0_s1 = x_s1_p1[3] ^ (^tc_s1_p1);

   // stage p2: d0 = a2 ^ NOR(a1,b0), e0 = a1 ^ NOR(b0,c0)
   always_ff @(posedge clk) begin
      td_s0_p2  <= hpc3_terms(~x_s0_p1[1], ~b0_s0,  b0_s1, Fresh[4], Fresh[5]);
      td_s1_p2  <= hpc3_terms( x_s1_p1[1],  b0_s1, ~b0_s0, Fresh[4], Fresh[5]);
      te_s0_p2  <= hpc3_terms(~b0_s0, ~c0_s0,  c0_s1, Fresh[6], Fresh[7]);
      te_s1_p2  <= hpc3_terms( b0_s1,  c0_s1, ~c0_s0, Fresh[6], Fresh[7]);
      a21_s0_p2 <= x_s0_p1[2:1];
      a21_s1_p2 <= x_s1_p1[2:1];
      bc_s0_p2  <= {b0_s0, c0_s0};
      bc_s1_p2  <= {b0_s1, c0_s1};
   end

   assign sbox_s0 = {bc_s0_p2, a21_s0_p2[1] ^ (^td_s0_p2), a21_s0_p2[0] ^ (^te_s0_p2)};
   assign sbox_s1 = {bc_s1_p2, a21_s1_p2[1] ^ (^td_s1_p2), a21_s1_p2[0] ^ (^te_s1_p2)};

   always_ff @(posedge clk) begin
      if (rst) begin
         res_s0 <= '0;
         res_s1 <= '0;
`ifdef SKINNY_SBOX_SHARE_CLEAR_EN
      end else if (accept) begin
         res_s0 <= '0;
         res_s1 <= '0;
`endif
      end else if (vld_p[SBOX_LAT-1]) begin
         res_s0[{idx_p[SBOX_LAT-1], 2'b00} +: 4] <= sbox_s0;
         res_s1[{idx_p[SBOX_LAT-1], 2'b00} +: 4] <= sbox_s1;
      end
   end

`ifdef SKINNY_SBOX_SHARE_CLEAR_EN
   assign state_out_s0 = busy ? '0 : res_s0;
   assign state_out_s1 = busy ? '0 : res_s1;
`else
   assign state_out_s0 = res_s0;
   assign state_out_s1 = res_s1;
`endif

endmodule

// File: tb/tb_skinny_sbox_layer_serial_d1.sv
// Directed bench for skinny_sbox_layer_serial_d1: recombined SubCells results, latency, handshake, reset abort.
module tb_skinny_sbox_layer_serial_d1;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [63:0] state_in_s0, state_in_s1;
   logic [7:0]  Fresh;
   logic        busy, done;
   logic [63:0] state_out_s0, state_out_s1;

   int n_checks = 0;
   int n_errors = 0;

   skinny_sbox_layer_serial_d1 dut (
      .clk(clk), .rst(rst), .start(start),
      .state_in_s0(state_in_s0), .state_in_s1(state_in_s1), .Fresh(Fresh),
      .busy(busy), .done(done),
      .state_out_s0(state_out_s0), .state_out_s1(state_out_s1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      Fresh = 8'($urandom());
   endtask

   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
         4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
         4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
         4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
      endcase
   endfunction

   function automatic logic [63:0] sub_cells(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sb(x[4*i +: 4]);
      return y;
   endfunction

   // start in current cycle (cycle 0); returns cycle of done and recombined result; ends in the IDLE cycle after FIN
   task automatic run_op(input string tag, input logic [63:0] s0, input logic [63:0] s1,
                         output int lat, output logic [63:0] rec);
      state_in_s0 = s0;
      state_in_s1 = s1;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      check({tag, "_busy_c1"}, 64'(busy), 64'd1);
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      rec = state_out_s0 ^ state_out_s1;
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   logic [63:0] x, m, rec, exp_rec;
   int          lat, cyc, ndone, dcyc;
   int          dcycs [3];
   logic [63:0] recs [3];
   logic [63:0] xs [3];
   logic [63:0] vx [4];
   logic [63:0] vm [4];
   logic [63:0] ve [4];

   initial begin
      rst = 1'b1; start = 1'b0; state_in_s0 = '0; state_in_s1 = '0; Fresh = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out_s0", state_out_s0, 64'd0);
      check("rst_out_s1", state_out_s1, 64'd0);
      tick();

      // unmasked vector
      run_op("unmasked", 64'hFEDCBA9876543210, 64'd0, lat, rec);
      check("unmasked_lat", 64'(lat), 64'd19);
      check("unmasked_res", rec, 64'hF7E4D583B2A1096C);

      // masked directed vectors, hand-computed results
      vx[0] = 64'hFEDCBA9876543210; vm[0] = 64'hA5A53C3C0F0F9696; ve[0] = 64'hF7E4D583B2A1096C;
      vx[1] = 64'h0123456789ABCDEF; vm[1] = 64'h5A5AC3C3F0F06969; ve[1] = 64'hC6901A2B385D4E7F;
      vx[2] = 64'h0000000000000000; vm[2] = 64'hFFFFFFFFFFFFFFFF; ve[2] = 64'hCCCCCCCCCCCCCCCC;
      vx[3] = 64'hFFFFFFFFFFFFFFFF; vm[3] = 64'h123456789ABCDEF0; ve[3] = 64'hFFFFFFFFFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         run_op("masked", vx[i] ^ vm[i], vm[i], lat, rec);
         check("masked_lat", 64'(lat), 64'd19);
         check("masked_res", rec, ve[i]);
      end

      // random X/M pairs against the table model
      for (int i = 0; i < 24; i++) begin
         x = {$urandom(), $urandom()};
         m = {$urandom(), $urandom()};
         run_op("rand", x ^ m, m, lat, rec);
         check("rand_res", rec, sub_cells(x));
      end

      // start pulses while busy are ignored
      x = 64'h0F1E2D3C4B5A6978; m = 64'h3141592653589793;
      state_in_s0 = x ^ m; state_in_s1 = m; start = 1'b1;
      tick();
      cyc = 1; ndone = 0; dcyc = 0; rec = '0;
      while (cyc <= 24) begin
         start = (cyc == 5 || cyc == 12);
         if (start) begin
            state_in_s0 = {$urandom(), $urandom()};
            state_in_s1 = {$urandom(), $urandom()};
         end
         if (done) begin
            ndone++;
            dcyc = cyc;
            rec = state_out_s0 ^ state_out_s1;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check("busy_start_ndone", 64'(ndone), 64'd1);
      check("busy_start_cyc", 64'(dcyc), 64'd19);
      check("busy_start_res", rec, sub_cells(x));

      // reset mid-operation at cycle 7, restart at cycle 9
      x = 64'h8899AABBCCDDEEFF; m = 64'h0102030405060708;
      state_in_s0 = x ^ m; state_in_s1 = m; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1; ndone = 0;
      while (cyc < 7) begin
         if (done) ndone++;
         tick();
         cyc++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 8;
      if (done) ndone++;
      check("midrst_ndone", 64'(ndone), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_out_s0", state_out_s0, 64'd0);
      check("midrst_out_s1", state_out_s1, 64'd0);
      tick();
      cyc = 9;
      x = 64'h1122334455667788; m = 64'hDEADBEEFCAFEF00D;
      run_op("restart", x ^ m, m, lat, rec);
      check("restart_done_cyc", 64'(cyc + lat), 64'd28);
      check("restart_res", rec, sub_cells(x));

      // start held high: back-to-back operations
      xs[0] = 64'hFEDCBA9876543210; xs[1] = 64'h0123456789ABCDEF; xs[2] = 64'h5A5A5A5AA5A5A5A5;
      m = 64'h6A09E667F3BCC908;
      state_in_s0 = xs[0] ^ m; state_in_s1 = m; start = 1'b1;
      tick();
      cyc = 1; ndone = 0;
      while (cyc <= 62) begin
         start = (cyc < 60);
`ifdef SKINNY_SBOX_SHARE_CLEAR_EN
         if (cyc == 10 || cyc == 30 || cyc == 50) begin
            check("b2b_out_s0_busy", state_out_s0, 64'd0);
            check("b2b_out_s1_busy", state_out_s1, 64'd0);
         end
`endif
         if (done) begin
            if (ndone < 3) begin
               dcycs[ndone] = cyc;
               recs[ndone]  = state_out_s0 ^ state_out_s1;
            end
            ndone++;
            if (ndone < 3) begin
               state_in_s0 = xs[ndone] ^ m;
               state_in_s1 = m;
            end
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check("b2b_ndone", 64'(ndone), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < ndone) begin
            check("b2b_done_cyc", 64'(dcycs[i]), 64'(19 + 20*i));
            check("b2b_res", recs[i], sub_cells(xs[i]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
